// File: rtl/poly_stream_unpacker.sv
// Unpacks one 256-coefficient ML-KEM polynomial from an AXI4-Stream into
// coefficient-memory rows, reducing each 12-bit lane modulo Q on the way.
module poly_stream_unpacker #(
  parameter int DWIDTH          = 256,
  parameter int COEFFS_PER_BEAT = 16,
  parameter int BEATS_PER_POLY  = 16,
  parameter int Q               = 3329
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [DWIDTH-1:0]                   s_axis_tdata,
  input  logic [DWIDTH/8-1:0]                 s_axis_tkeep,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic                                wr_en,
  output logic [$clog2(BEATS_PER_POLY)-1:0]   wr_addr,
  output logic [12*COEFFS_PER_BEAT-1:0]       wr_data,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int AW = $clog2(BEATS_PER_POLY);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                       state_q, state_d;
  logic [AW-1:0]                cnt_q, cnt_d;
  logic                         accept;
  logic                         last_beat;
  logic                         final_beat;
  logic                         keep_full;
  logic [12*COEFFS_PER_BEAT-1:0] reduced;
  logic [4*COEFFS_PER_BEAT-1:0]  unused_hi;

  // Lane values are at most 4095 < 2Q, so one conditional subtract fully reduces them.
  for (genvar g = 0; g < COEFFS_PER_BEAT; g++) begin : g_lane
    logic [11:0] v;
    assign v                    = s_axis_tdata[16*g +: 12];
    assign reduced[12*g +: 12]  = (v >= 12'(Q)) ? v - 12'(Q) : v;
    assign unused_hi[4*g +: 4]  = s_axis_tdata[16*g+12 +: 4];
  end

  assign s_axis_tready = (state_q == LOAD);
  assign busy          = (state_q == LOAD);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_beat     = (cnt_q == AW'(BEATS_PER_POLY - 1));
  assign final_beat    = s_axis_tlast || last_beat;
  assign keep_full     = &s_axis_tkeep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (final_beat) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A tlast that disagrees with the beat position is a framing error either way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      wr_en <= accept;
      done  <= accept && final_beat;
      if (accept) begin
        wr_addr <= cnt_q;
        wr_data <= reduced;
      end
      if (state_q == IDLE && start) begin
        err <= 1'b0;
      end else if (accept && (!keep_full || (s_axis_tlast != last_beat))) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_poly_stream_unpacker.sv
// Directed bench for poly_stream_unpacker: a spec-level model checked every cycle,
// plus literal expectations per scenario.
module tb_poly_stream_unpacker;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [255:0] s_axis_tdata = '0;
  logic [31:0]  s_axis_tkeep = '1;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [191:0] wr_data;
  logic         busy;
  logic         done;
  logic         err;

  int total = 0;
  int bad   = 0;

  poly_stream_unpacker dut (
    .clk(clk), .rst(rst), .start(start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] expectRow(input logic [255:0] d);
    logic [191:0] r;
    int v;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      v = int'(d[16*i +: 16]) % 4096;
      if (v >= 3329) v = v - 3329;
      r[12*i +: 12] = v[11:0];
    end
    return r;
  endfunction

  function automatic logic [255:0] countBeat(input int k);
    logic [255:0] d;
    for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'(16*k + i);
    return d;
  endfunction

  // Spec-level model: a loading flag, the row being filled and what the next cycle must show.
  bit           m_loading, m_wr_en, m_done, m_err;
  int           m_row, m_addr;
  logic [191:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading = 0; m_row = 0; m_wr_en = 0; m_done = 0; m_err = 0; m_addr = 0; m_data = '0;
    end else begin
      m_wr_en = 0;
      m_done  = 0;
      if (!m_loading) begin
        if (start) begin
          m_loading = 1; m_row = 0; m_err = 0;
        end
      end else if (s_axis_tvalid) begin
        m_wr_en = 1;
        m_addr  = m_row;
        m_data  = expectRow(s_axis_tdata);
        if (s_axis_tkeep != 32'hFFFF_FFFF) m_err = 1;
        if (s_axis_tlast && m_row < 15)    m_err = 1;
        if (!s_axis_tlast && m_row == 15)  m_err = 1;
        if (s_axis_tlast || m_row == 15) begin
          m_done = 1; m_loading = 0; m_row = 0;
        end else begin
          m_row = m_row + 1;
        end
      end
    end
  end

  logic [191:0] cap [16];
  int wr_count, done_count, done_addr, cycle;
  int addr_log[$];
  int wr_cycles[$];

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    checkOutput("tready", s_axis_tready, m_loading);
    checkOutput("busy", busy, m_loading);
    checkOutput("wr_en", wr_en, m_wr_en);
    checkOutput("done", done, m_done);
    checkOutput("err", err, m_err);
    if (m_wr_en) begin
      checkOutput("wr_addr", wr_addr, 192'(m_addr));
      checkOutput("wr_data", wr_data, m_data);
    end
    if (wr_en) begin
      cap[wr_addr] = wr_data;
      wr_count++;
      addr_log.push_back(int'(wr_addr));
      wr_cycles.push_back(cycle);
      if (done) begin
        done_count++;
        done_addr = int'(wr_addr);
      end
    end
  end

  task automatic applyStimulus(input logic st, input logic vld, input logic lst,
                               input logic [255:0] data, input logic [31:0] keep);
    @(posedge clk);
    #1;
    start = st; s_axis_tvalid = vld; s_axis_tlast = lst; s_axis_tdata = data; s_axis_tkeep = keep;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '1);
  endtask

  task automatic runBeats(input int first, input int last, input int gap, input int tlastBeat,
                          input int badKeepBeat, input int startBeat);
    for (int k = first; k <= last; k++) begin
      applyStimulus(k == startBeat, 1'b1, k == tlastBeat, countBeat(k),
                    (k == badKeepBeat) ? 32'h0000_FFFF : 32'hFFFF_FFFF);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0, countBeat(99), '1);
    end
  endtask

  task automatic resetCapture();
    wr_count = 0; done_count = 0; done_addr = -1;
    addr_log.delete();
    wr_cycles.delete();
  endtask

  task automatic checkOrder(input string name, input int n, input int span);
    bit ok;
    ok = (addr_log.size() == n) && (wr_cycles.size() == n);
    if (ok) begin
      for (int i = 0; i < n; i++) if (addr_log[i] != i) ok = 0;
      if (wr_cycles[n-1] - wr_cycles[0] != span) ok = 0;
    end
    checkOutput(name, ok, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetCapture();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_tready", s_axis_tready, 1'b0);
    checkOutput("rst_wr_en", wr_en, 1'b0);
    checkOutput("rst_wr_addr", wr_addr, '0);
    checkOutput("rst_wr_data", wr_data, '0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // Back-to-back full load with counting lanes.
    resetCapture();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '1);
    runBeats(0, 15, 0, 15, -1, -1);
    idle(3);
    checkOutput("b2b_count", 192'(wr_count), 192'(16));
    checkOutput("b2b_done_addr", 192'(done_addr), 192'(15));
    checkOutput("b2b_done_count", 192'(done_count), 192'(1));
    checkOutput("b2b_err", err, 1'b0);
    checkOutput("b2b_row0_lane0", cap[0][11:0], 192'(0));
    checkOutput("b2b_row5_lane3", cap[5][47:36], 192'(83));
    checkOutput("b2b_row15_lane15", cap[15][191:180], 192'(255));
    checkOrder("b2b_order", 16, 15);

    // Reduction boundaries on beat 0.
    resetCapture();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '1);
    applyStimulus(1'b0, 1'b1, 1'b0, {4{16'hFD00, 16'h0D00, 16'h0D01, 16'h0FFF}}, '1);
    runBeats(1, 15, 0, 15, -1, -1);
    idle(3);
    checkOutput("red_0fff", cap[0][11:0], 192'(766));
    checkOutput("red_0d01", cap[0][23:12], 192'(0));
    checkOutput("red_0d00", cap[0][35:24], 192'(3328));
    checkOutput("red_fd00", cap[0][47:36], 192'(3328));
    checkOutput("red_lane15", cap[0][191:180], 192'(3328));
    checkOutput("red_count", 192'(wr_count), 192'(16));

    // tvalid toggling, start ignored mid-load, no tlast on beat 15.
    resetCapture();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '1);
    runBeats(0, 15, 1, -1, -1, 4);
    idle(3);
    checkOrder("tog_order", 16, 30);
    checkOutput("tog_done_count", 192'(done_count), 192'(1));
    checkOutput("tog_err_no_tlast", err, 1'b1);

    // Early tlast on beat 5.
    resetCapture();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '1);
    runBeats(0, 5, 0, 5, -1, -1);
    idle(3);
    checkOutput("early_count", 192'(wr_count), 192'(6));
    checkOutput("early_done_addr", 192'(done_addr), 192'(5));
    checkOutput("early_err", err, 1'b1);
    checkOutput("early_tready", s_axis_tready, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '1);
    idle(1);
    checkOutput("early_err_cleared", err, 1'b0);
    checkOutput("early_busy_again", busy, 1'b1);
    resetCapture();
    runBeats(0, 15, 0, 15, -1, -1);
    idle(3);
    checkOutput("early_reload_count", 192'(wr_count), 192'(16));

    // Partial tkeep on beat 3, start on the final beat ignored.
    resetCapture();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '1);
    runBeats(0, 15, 0, 15, 3, 15);
    idle(1);
    checkOutput("keep_busy_after_last", busy, 1'b0);
    idle(2);
    checkOutput("keep_row3", cap[3], expectRow(countBeat(3)));
    checkOutput("keep_done_addr", 192'(done_addr), 192'(15));
    checkOutput("keep_err", err, 1'b1);

    // Reset after beat 7.
    resetCapture();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '1);
    runBeats(0, 7, 0, -1, -1, -1);
    @(posedge clk);
    #6 rst = 1'b1;
    #1;
    checkOutput("mid_rst_wr_en", wr_en, 1'b0);
    checkOutput("mid_rst_wr_addr", wr_addr, '0);
    checkOutput("mid_rst_wr_data", wr_data, '0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_tready", s_axis_tready, 1'b0);
    @(posedge clk); #1 s_axis_tvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    idle(3);
    checkOutput("mid_rst_count", 192'(wr_count), 192'(8));
    resetCapture();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '1);
    runBeats(0, 15, 0, 15, -1, -1);
    idle(3);
    checkOutput("fresh_count", 192'(wr_count), 192'(16));
    checkOutput("fresh_done_addr", 192'(done_addr), 192'(15));
    checkOutput("fresh_err", err, 1'b0);
    checkOutput("fresh_row8_lane0", cap[8][11:0], 192'(128));
    checkOrder("fresh_order", 16, 15);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_stream_unpacker.md
POLY_STREAM_UNPACKER -- requirements
Module: poly_stream_unpacker

Interface
REQ-001 SHALL have parameter DWIDTH, default 256, AXI4-Stream data width in bits.
REQ-002 SHALL have parameter COEFFS_PER_BEAT, default 16, coefficients per beat, each a 16-bit storage lane.
REQ-003 SHALL have parameter BEATS_PER_POLY, default 16, beats per 256-coefficient polynomial.
REQ-004 SHALL have parameter Q, default 3329, ML-KEM modulus.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 start  input  1  single-cycle request to load one polynomial.
REQ-009 s_axis_tdata  input  DWIDTH  16 lanes of 16 bits; lane i = bits [16i+15:16i].
REQ-010 s_axis_tkeep  input  DWIDTH/8  byte enables.
REQ-011 s_axis_tvalid  input  1  beat valid.
REQ-012 s_axis_tlast  input  1  last beat of polynomial.
REQ-013 s_axis_tready  output  1  beat accepted when high with tvalid.
REQ-014 wr_en  output  1  coefficient-memory row write strobe.
REQ-015 wr_addr  output  4  row index (= beat index 0..15).
REQ-016 wr_data  output  192  16 reduced 12-bit coefficients; lane i = bits [12i+11:12i].
REQ-017 busy  output  1  high while a load is in progress.
REQ-018 done  output  1  one-cycle pulse with the final row write.
REQ-019 err  output  1  sticky framing error, cleared by next accepted start.

Function
REQ-020 SHALL implement states IDLE and LOAD; busy = (state == LOAD).
REQ-021 IDLE: tready = 0; start moves to LOAD, clears beat counter to 0 and err to 0.
REQ-022 start while in LOAD SHALL be ignored.
REQ-023 LOAD: tready = 1 combinationally; no internal backpressure.
REQ-024 Beat accepted only when tvalid && tready; tvalid low in LOAD holds all state.
REQ-025 Each accepted beat k SHALL produce, exactly one cycle later, wr_en = 1, wr_addr = k, wr_data registered; otherwise wr_en = 0.
REQ-026 Lane reduction: v = lane bits [11:0]; output v - Q if v >= Q, else v; bits [15:12] ignored.
REQ-027 Counter increments per accepted beat; beat 15 (wrap point) returns state to IDLE, counter to 0.
REQ-028 Accepted beat with tlast = 1 and k < 15 SHALL end load: row k written, done pulsed, err set, state IDLE.
REQ-029 Beat 15 accepted with tlast = 0 SHALL still complete normally, with err set.
REQ-030 Any accepted beat with tkeep != all ones SHALL set err; data still written unchanged.
REQ-031 done SHALL assert in the same cycle as the final wr_en, for exactly one cycle.
REQ-032 start asserted in the cycle the final beat is accepted SHALL be ignored; a new start is honoured from the next cycle (IDLE).
REQ-033 Maximum throughput: one beat per cycle, 16 rows in 16 cycles, done at cycle 17 after first acceptance.

Reset
REQ-034 rst SHALL immediately force state IDLE, counter 0, tready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, err 0.
REQ-035 rst mid-load SHALL abandon the polynomial; no further wr_en until a new start.
REQ-036 After rst deassertion, first start SHALL behave as from power-up.

Verification
REQ-037 start, then 16 back-to-back beats with lane values 0..255, tlast on beat 15 -> rows 0..15 written in consecutive cycles, values unchanged, done with row 15, err 0.
REQ-038 All lanes 0x0FFF, 0x0D01 (3329), 0x0D00 (3328), 0xFD00 -> outputs 766, 0, 3328, 3328.
REQ-039 tvalid toggling 1/0 across 16 beats -> wr_en only after accepted beats, wr_addr 0..15 in order, no duplicated or skipped rows.
REQ-040 tlast on beat 5 -> rows 0..5 written, done with row 5, err 1, tready 0 next cycle; following start clears err.
REQ-041 tkeep = 0x0000FFFF on beat 3 -> row 3 written, done at row 15, err 1.
REQ-042 rst asserted after beat 7 accepted -> all outputs 0 same cycle, no row 8 write; fresh 16-beat load then passes REQ-037.
